// File: rtl/dual_port_memory_manager.sv
// dual_port_memory_manager: true dual-port RAM with a post-reset zero-fill engine.
// Define MEM_OUTPUT_REG_EN to add an output register stage (read latency 2).
module dual_port_memory_manager #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 15,
  parameter int WRITE_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  input  logic                  enA,
  input  logic                  wenA,
  input  logic [ADDR_WIDTH-1:0] AddressA,
  input  logic [DATA_WIDTH-1:0] WriteDataA,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic                  validA,
  input  logic                  enB,
  input  logic                  wenB,
  input  logic [ADDR_WIDTH-1:0] AddressB,
  input  logic [DATA_WIDTH-1:0] WriteDataB,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  output logic                  validB
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH:0] ptr, ptr_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic val_a, val_b, acc_a, acc_b, clr, same;
  always_ff @(posedge clk)
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  // The extra pointer bit sets on the increment past the last address.
  always_comb begin
    ptr_n   = (state == CLEAR) ? ptr + (ADDR_WIDTH+1)'(1) : ptr;
    state_n = (state == CLEAR && ptr_n[ADDR_WIDTH]) ? READY : state;
  end
  assign busy  = state == CLEAR;
  assign clr   = busy && !reset;
  assign acc_a = enA && !busy && !reset;
  assign acc_b = enB && !busy && !reset;
  assign same  = AddressA == AddressB;
  // Port A wins a same-address write collision.
  always_ff @(posedge clk)
    if (clr) mem[ptr[ADDR_WIDTH-1:0]] <= '0;
    else begin
      if (acc_a && wenA) mem[AddressA] <= WriteDataA;
      if (acc_b && wenB && !(acc_a && wenA && same)) mem[AddressB] <= WriteDataB;
    end
  always_ff @(posedge clk)
    if (reset) begin
      rd_a  <= '0;
      rd_b  <= '0;
      val_a <= 1'b0;
      val_b <= 1'b0;
    end else begin
      val_a <= acc_a;
      val_b <= acc_b;
      if (acc_a) rd_a <= (wenA && WRITE_FIRST != 0) ? WriteDataA : mem[AddressA];
      if (acc_b) rd_b <= (wenB && WRITE_FIRST != 0) ? WriteDataB : mem[AddressB];
    end
`ifdef MEM_OUTPUT_REG_EN
  always_ff @(posedge clk)
    if (reset) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
      validA    <= 1'b0;
      validB    <= 1'b0;
    end else begin
      ReadDataA <= rd_a;
      ReadDataB <= rd_b;
      validA    <= val_a;
      validB    <= val_b;
    end
`else
  assign ReadDataA = rd_a;
  assign ReadDataB = rd_b;
  assign validA    = val_a;
  assign validB    = val_b;
`endif
endmodule

// File: tb/tb_dual_port_memory_manager.sv
// tb_dual_port_memory_manager: write-first and read-first instances checked against a behavioural model.
module tb_dual_port_memory_manager;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 16;
`ifdef MEM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0;
  logic reset = 0;
  logic enA = 0, wenA = 0, enB = 0, wenB = 0;
  logic [AW-1:0] AddressA = '0, AddressB = '0;
  logic [DW-1:0] WriteDataA = '0, WriteDataB = '0;
  logic busy1, va1, vb1, busy0, va0, vb0;
  logic [DW-1:0] rda1, rdb1, rda0, rdb0;
  int n_vec = 0, n_err = 0;
  logic [DW-1:0] mm [DEPTH];
  int cnt;
  bit mbusy;
  logic [DW-1:0] e_rd [2][2], e_rd2 [2][2];
  bit e_v [2], e_v2 [2];
  always #5 clk = ~clk;
  dual_port_memory_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .busy(busy1),
    .enA(enA), .wenA(wenA), .AddressA(AddressA), .WriteDataA(WriteDataA), .ReadDataA(rda1), .validA(va1),
    .enB(enB), .wenB(wenB), .AddressB(AddressB), .WriteDataB(WriteDataB), .ReadDataB(rdb1), .validB(vb1));
  dual_port_memory_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .busy(busy0),
    .enA(enA), .wenA(wenA), .AddressA(AddressA), .WriteDataA(WriteDataA), .ReadDataA(rda0), .validA(va0),
    .enB(enB), .wenB(wenB), .AddressB(AddressB), .WriteDataB(WriteDataB), .ReadDataB(rdb0), .validB(vb0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit r, input bit ea, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input bit eb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] oa, ob;
    reset = r; enA = ea; wenA = wa; AddressA = aa; WriteDataA = da;
    enB = eb; wenB = wb; AddressB = ab; WriteDataB = db;
    @(posedge clk);
    if (r) begin
      mbusy = 1; cnt = 0;
      e_rd = '{default: '0}; e_rd2 = '{default: '0};
      e_v = '{default: 0}; e_v2 = '{default: 0};
    end else begin
      e_rd2 = e_rd; e_v2 = e_v;
      if (mbusy) begin
        mm[cnt] = '0;
        cnt++;
        if (cnt == DEPTH) mbusy = 0;
        e_v = '{default: 0};
      end else begin
        oa = mm[aa]; ob = mm[ab];
        e_v[0] = ea; e_v[1] = eb;
        if (ea) begin e_rd[1][0] = wa ? da : oa; e_rd[0][0] = oa; end
        if (eb) begin e_rd[1][1] = wb ? db : ob; e_rd[0][1] = ob; end
        if (ea && wa) mm[aa] = da;
        if (eb && wb && !(ea && wa && aa == ab)) mm[ab] = db;
      end
    end
    #1;
    chk("busy_wf1", busy1, mbusy);
    chk("busy_wf0", busy0, mbusy);
    chk("validA_wf1", va1, LAT == 1 ? e_v[0] : e_v2[0]);
    chk("validB_wf1", vb1, LAT == 1 ? e_v[1] : e_v2[1]);
    chk("validA_wf0", va0, LAT == 1 ? e_v[0] : e_v2[0]);
    chk("validB_wf0", vb0, LAT == 1 ? e_v[1] : e_v2[1]);
    chk("rdA_wf1", rda1, LAT == 1 ? e_rd[1][0] : e_rd2[1][0]);
    chk("rdB_wf1", rdb1, LAT == 1 ? e_rd[1][1] : e_rd2[1][1]);
    chk("rdA_wf0", rda0, LAT == 1 ? e_rd[0][0] : e_rd2[0][0]);
    chk("rdB_wf0", rdb0, LAT == 1 ? e_rd[0][1] : e_rd2[0][1]);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask
  initial begin
    int n;
    bit ea, eb;
    logic [AW-1:0] aa, ab;
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0);
    chk("reset_busy", busy1, 1);
    chk("reset_rdA", rda1, 0);
    tick(0, 1, 1, 4'd3, 16'hBEEF, 0, 0, '0, '0);
    chk("clear_req_validA", va1, 0);
    n = 1;
    while (busy1 && n < 100) begin idle(1); n++; end
    chk("busy_len", n, 16);
    for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, AW'(i), '0, 1, 0, AW'(15 - i), '0);
    idle(LAT - 1);
    chk("clear_last_validA", va1, 1);
    tick(0, 1, 0, 4'd3, '0, 0, 0, '0, '0);
    idle(LAT - 1);
    chk("addr3_after_clear", rda1, 16'h0000);
    tick(0, 1, 1, 4'd5, 16'h1234, 0, 0, '0, '0);
    idle(LAT - 1);
    chk("wr5_rdA", rda1, 16'h1234);
    tick(0, 0, 0, '0, '0, 1, 0, 4'd5, '0);
    idle(LAT - 1);
    chk("rd5_rdB", rdb1, 16'h1234);
    chk("rd5_validB", vb1, 1);
    tick(0, 1, 1, 4'd7, 16'hAAAA, 1, 1, 4'd7, 16'h5555);
    idle(LAT - 1);
    chk("wcol_rdA_wf1", rda1, 16'hAAAA);
    chk("wcol_rdB_wf1", rdb1, 16'h5555);
    chk("wcol_rdA_wf0", rda0, 16'h0000);
    chk("wcol_rdB_wf0", rdb0, 16'h0000);
    tick(0, 1, 0, 4'd7, '0, 0, 0, '0, '0);
    idle(LAT - 1);
    chk("wcol_mem7", rda1, 16'hAAAA);
    tick(0, 1, 1, 4'd2, 16'h0011, 0, 0, '0, '0);
    tick(0, 1, 1, 4'd2, 16'h2222, 1, 0, 4'd2, '0);
    idle(LAT - 1);
    chk("mcol_rdB", rdb1, 16'h0011);
    chk("mcol_rdA", rda1, 16'h2222);
    tick(0, 1, 0, 4'd2, '0, 0, 0, '0, '0);
    idle(LAT - 1);
    chk("mcol_mem2", rda1, 16'h2222);
    for (int i = 0; i < 400; i++) begin
      ea = $urandom_range(0, 3) != 0;
      eb = $urandom_range(0, 3) != 0;
      aa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 2));
      ab = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 2));
      tick(0, ea, $urandom_range(0, 1) != 0, aa, DW'($urandom), eb, $urandom_range(0, 1) != 0, ab, DW'($urandom));
    end
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(6);
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0);
    n = 0;
    while (busy1 && n < 100) begin idle(1); n++; end
    chk("busy_len_rst2", n, 16);
    tick(0, 1, 0, 4'd9, '0, 0, 0, '0, '0);
    n = 1;
    while (!va1 && n < 5) begin idle(1); n++; end
    chk("read_latency", n, LAT);
    chk("addr9_data", rda1, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
